mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum wait cycles for a data-memory acknowledge before the access is aborted.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- RegWr_EX  in  1  register-write enable from EX/MEM.
- MemWr_EX  in  1  store request.
- MemRd_EX  in  1  load request.
- WBdata_EX  in  2  writeback select: 00 ALU, 01 memory, 10 npc.
- ALUout_EX  in  32  ALU result and byte address.
- D  in  32  store data.
- npc3  in  32  next PC.
- rd3  in  5  destination register.
- RPzero_EX  in  1  squash flag; 1 = instruction annulled.
- dm_req  out  1  data-memory request.
- dm_we  out  1  1 = write, 0 = read.
- dm_addr  out  32  byte address.
- dm_wdata  out  32  store data.
- dm_ack  in  1  memory completes the access this cycle.
- dm_rdata  in  32  load data; valid when dm_ack = 1.
- stall  out  1  freezes the upstream stages.
- RegWr_MEM  out  1  MEM/WB register-write enable.
- rd4  out  5  MEM/WB destination register.
- WBval  out  32  MEM/WB writeback value.
- mem_err  out  1  sticky error flag for misaligned or timed-out accesses.

Function
REQ-003 An access SHALL be valid when (MemRd_EX or MemWr_EX), RPzero_EX = 0, and ALUout_EX[1:0] = 00.
REQ-004 Two-state FSM, IDLE and WAIT:
- IDLE -> WAIT when a valid access is present and dm_ack = 0.
- WAIT -> IDLE on dm_ack = 1 or on timeout.
REQ-005 dm_req SHALL be combinational: 1 in IDLE when a valid access is present, and 1 in WAIT until dm_ack is seen.
REQ-006 dm_we SHALL equal MemWr_EX. dm_addr SHALL equal ALUout_EX. dm_wdata SHALL equal D.
REQ-007 stall SHALL be combinational: 1 whenever dm_req = 1 and dm_ack = 0. Upstream holds all inputs stable while stall = 1.
REQ-008 A zero-wait ack (dm_ack = 1 in the same cycle as the IDLE request) SHALL complete with no stall, giving 1-cycle latency.
REQ-009 The MEM/WB register SHALL update every cycle.
- Completing cycle: RegWr_MEM = RegWr_EX & ~RPzero_EX; rd4 = rd3; WBval = mux(WBdata_EX).
- Stall cycle: RegWr_MEM = 0 (bubble); rd4 and WBval are don't-care.
REQ-010 WBval select: 00 -> ALUout_EX; 01 -> dm_rdata captured on ack; 10 -> npc3; 11 -> 0.
REQ-011 With RPzero_EX = 1 there SHALL be no dm_req and RegWr_MEM = 0, in a single cycle with no stall.
REQ-012 If MemRd_EX and MemWr_EX are both 1, the access SHALL be treated as a write.
REQ-013 A misaligned access (ALUout_EX[1:0] != 0) with a memory op and RPzero_EX = 0 SHALL:
- issue no dm_req,
- set mem_err,
- force RegWr_MEM = 0,
- complete in 1 cycle.
REQ-014 Timeout handling:
- An 8-bit wait counter SHALL clear on entering WAIT and increment in every WAIT cycle without ack.
- When count = TIMEOUT with no ack: abort to IDLE, set mem_err, RegWr_MEM = 0, stall = 0 in that cycle.
- dm_ack arriving in the same cycle as the timeout SHALL win (normal completion).
REQ-015 mem_err SHALL stay set until reset.

Reset
REQ-016 While rst = 1 at a clock edge, the block SHALL set: FSM = IDLE, counter = 0, RegWr_MEM = 0, rd4 = 0, WBval = 0, mem_err = 0.
REQ-017 While rst = 1, dm_req and stall SHALL be 0, including during a WAIT in progress; the pending access is dropped.

Structure
REQ-018 A shared package SHALL hold the WBdata encodings (WB_ALU = 2'b00, WB_MEM = 2'b01, WB_NPC = 2'b10) and the FSM state enum; the Execute and writeback stages use the same package.
REQ-019 The writeback-value mux SHALL be a sub-module, wb_mux; all other logic stays inline.

Verification
REQ-020 Load, zero-wait: MemRd = 1, ALUout = 0x100, WBdata = 01, rd3 = 7, dm_ack = 1 with rdata = 0xDEADBEEF in the same cycle -> stall never 1; next edge gives RegWr_MEM = 1, rd4 = 7, WBval = 0xDEADBEEF.
REQ-021 Store, 3-wait: MemWr = 1, ALUout = 0x40, D = 0x12345678, ack on the 4th cycle -> stall = 1 for 3 cycles; dm_we = 1 with addr and wdata stable throughout; then RegWr_MEM = 0 if RegWr_EX = 0.
REQ-022 Squash: MemRd = 1, RPzero_EX = 1, RegWr_EX = 1 -> dm_req = 0, stall = 0, RegWr_MEM = 0.
REQ-023 Misaligned: MemRd = 1, ALUout = 0x102 -> dm_req = 0, mem_err = 1 after the edge and held, RegWr_MEM = 0.
REQ-024 Timeout: TIMEOUT = 4, no ack -> stall = 1 for 4 cycles, then stall = 0 and mem_err = 1; a repeat run with ack in the 4th WAIT cycle instead completes normally with mem_err = 0.
REQ-025 Reset mid-WAIT: rst = 1 during cycle 2 of a WAIT -> next cycle FSM = IDLE, dm_req = 0, all outputs at their reset values.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage and its neighbours: writeback-select
// encodings, the MEM access FSM states and a word-alignment helper.
package mem_stage_pkg;

  typedef logic [1:0] wb_sel_t;

  localparam wb_sel_t WB_ALU = 2'b00;
  localparam wb_sel_t WB_MEM = 2'b01;
  localparam wb_sel_t WB_NPC = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  localparam int WAIT_CNT_W = 8;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the
// data memory (slave).
interface mem_stage_if;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req,
    output dm_we,
    output dm_addr,
    output dm_wdata,
    input  dm_ack,
    input  dm_rdata
  );

  modport slave (
    input  dm_req,
    input  dm_we,
    input  dm_addr,
    input  dm_wdata,
    output dm_ack,
    output dm_rdata
  );

endinterface

// File: rtl/mem_stage_wb_mux.sv
// Writeback-value select for the MEM/WB register. The unused 2'b11 code
// yields zero so an undefined select never leaks stale data.
module wb_mux
  import mem_stage_pkg::*;
(
  input  wb_sel_t     i_sel,
  input  logic [31:0] i_alu,
  input  logic [31:0] i_mem,
  input  logic [31:0] i_npc,
  output logic [31:0] o_val
);

  // Pick the writeback source by select code
  always_comb begin
    o_val = 32'h0;
    case (i_sel)
      WB_ALU:  o_val = i_alu;
      WB_MEM:  o_val = i_mem;
      WB_NPC:  o_val = i_npc;
      default: o_val = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses, stalls upstream while the
// memory is busy, aborts on timeout and loads the MEM/WB register.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no access outstanding; a valid access is requested here and
//         | completes at once if the memory acks in the same cycle
// ST_WAIT | access outstanding, waiting for dm_ack or timeout
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWr_EX,
  input  logic        MemWr_EX,
  input  logic        MemRd_EX,
  input  wb_sel_t     WBdata_EX,
  input  logic [31:0] ALUout_EX,
  input  logic [31:0] D,
  input  logic [31:0] npc3,
  input  logic [4:0]  rd3,
  input  logic        RPzero_EX,
  mem_stage_if.master dm,
  output logic        stall,
  output logic        RegWr_MEM,
  output logic [4:0]  rd4,
  output logic [31:0] WBval,
  output logic        mem_err
);

  localparam logic [WAIT_CNT_W-1:0] L_TMO = WAIT_CNT_W'(TIMEOUT);

  mem_state_t            r_state;
  mem_state_t            w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic [WAIT_CNT_W-1:0] w_wait_cnt_nxt;
  logic [WAIT_CNT_W-1:0] w_wait_cnt_inc;

  logic        w_mem_op;
  logic        w_valid;
  logic        w_misalign;
  logic        w_req;
  logic        w_complete;
  logic        w_timeout;
  logic [31:0] w_wb_val;

  assign w_mem_op       = MemRd_EX | MemWr_EX;
  assign w_valid        = w_mem_op & ~RPzero_EX & is_word_aligned(ALUout_EX);
  assign w_misalign     = w_mem_op & ~RPzero_EX & ~is_word_aligned(ALUout_EX);
  assign w_wait_cnt_inc = r_wait_cnt + 1'b1;

  // Store wins when both load and store are flagged, since dm_we follows MemWr
  assign dm.dm_req   = w_req;
  assign dm.dm_we    = MemWr_EX;
  assign dm.dm_addr  = ALUout_EX;
  assign dm.dm_wdata = D;
  assign stall       = w_req & ~dm.dm_ack;

  // Next state, request and completion; the timeout fires in the WAIT cycle
  // whose increment brings the count to TIMEOUT, so TIMEOUT is the total
  // number of stall cycles an unanswered access costs. A late ack in that
  // same cycle still completes normally.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_req          = 1'b0;
    w_complete     = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_wait_cnt_nxt = '0;
        if (w_valid) begin
          w_req = 1'b1;
          if (dm.dm_ack) begin
            w_complete = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end else begin
          w_complete = 1'b1;
        end
      end
      ST_WAIT: begin
        if (dm.dm_ack) begin
          w_req       = 1'b1;
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_wait_cnt_inc == L_TMO) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_req          = 1'b1;
          w_wait_cnt_nxt = w_wait_cnt_inc;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_wait_cnt_nxt = '0;
      end
    endcase
    if (rst) begin
      w_req = 1'b0;
    end
  end

  // FSM state and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  wb_mux u_wb_mux (
    .i_sel (WBdata_EX),
    .i_alu (ALUout_EX),
    .i_mem (dm.dm_rdata),
    .i_npc (npc3),
    .o_val (w_wb_val)
  );

  // MEM/WB register; stalls, aborts and squashes all leave a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWr_MEM <= 1'b0;
      rd4       <= '0;
      WBval     <= '0;
    end else begin
      RegWr_MEM <= w_complete & RegWr_EX & ~RPzero_EX & ~w_misalign;
      rd4       <= rd3;
      WBval     <= w_wb_val;
    end
  end

  // Sticky error for misaligned or timed-out accesses
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_err <= 1'b0;
    end else if ((r_state == ST_IDLE && w_misalign) || w_timeout) begin
      mem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: the driver pushes expected values into a
// scoreboard queue tagged with the cycle they apply to; a monitor on the
// falling edge pops and compares them.
module tb_mem_stage;

  localparam int S_REQ   = 0;
  localparam int S_STALL = 1;
  localparam int S_WE    = 2;
  localparam int S_ADDR  = 3;
  localparam int S_WDATA = 4;
  localparam int S_RWM   = 5;
  localparam int S_RD4   = 6;
  localparam int S_WBV   = 7;
  localparam int S_ERR   = 8;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWr_EX, MemWr_EX, MemRd_EX, RPzero_EX;
  logic [1:0]  WBdata_EX;
  logic [31:0] ALUout_EX, D, npc3;
  logic [4:0]  rd3;
  logic        stall, RegWr_MEM, mem_err;
  logic [4:0]  rd4;
  logic [31:0] WBval;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t it;

  mem_stage_if dm_bus ();

  mem_stage #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .RegWr_EX  (RegWr_EX),
    .MemWr_EX  (MemWr_EX),
    .MemRd_EX  (MemRd_EX),
    .WBdata_EX (WBdata_EX),
    .ALUout_EX (ALUout_EX),
    .D         (D),
    .npc3      (npc3),
    .rd3       (rd3),
    .RPzero_EX (RPzero_EX),
    .dm        (dm_bus),
    .stall     (stall),
    .RegWr_MEM (RegWr_MEM),
    .rd4       (rd4),
    .WBval     (WBval),
    .mem_err   (mem_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input int sig);
    case (sig)
      S_REQ:   return {31'h0, dm_bus.dm_req};
      S_STALL: return {31'h0, stall};
      S_WE:    return {31'h0, dm_bus.dm_we};
      S_ADDR:  return dm_bus.dm_addr;
      S_WDATA: return dm_bus.dm_wdata;
      S_RWM:   return {31'h0, RegWr_MEM};
      S_RD4:   return {27'h0, rd4};
      S_WBV:   return WBval;
      S_ERR:   return {31'h0, mem_err};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      it = sb_q.pop_front();
      checks++;
      if (sample(it.sig) !== it.exp) begin
        errors++;
        $display("FAIL %s cyc=%0d actual=%h required=%h", it.name, cyc, sample(it.sig), it.exp);
      end
    end
  end

  task automatic ex(input int d, input int sig, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc + d;
    e.sig  = sig;
    e.exp  = v;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    RegWr_EX = 0; MemWr_EX = 0; MemRd_EX = 0; RPzero_EX = 0;
    WBdata_EX = 2'b00; ALUout_EX = 32'h0; D = 32'h0; npc3 = 32'h0; rd3 = 5'd0;
    dm_bus.dm_ack = 0; dm_bus.dm_rdata = 32'h0;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle_in();
    tick();
    // Reset held with a valid access present: no request, no stall
    MemRd_EX = 1; ALUout_EX = 32'h100;
    ex(0, S_REQ, 0, "rst_req"); ex(0, S_STALL, 0, "rst_stall");
    ex(1, S_RWM, 0, "rst_rwm"); ex(1, S_RD4, 0, "rst_rd4");
    ex(1, S_WBV, 0, "rst_wbv"); ex(1, S_ERR, 0, "rst_err");
    tick();
    rst = 0;
    idle_in();
    tick();

    // Zero-wait load
    RegWr_EX = 1; MemRd_EX = 1; ALUout_EX = 32'h100; WBdata_EX = 2'b01; rd3 = 5'd7;
    dm_bus.dm_ack = 1; dm_bus.dm_rdata = 32'hDEAD_BEEF;
    ex(0, S_REQ, 1, "zw_req"); ex(0, S_STALL, 0, "zw_stall"); ex(0, S_WE, 0, "zw_we");
    ex(1, S_RWM, 1, "zw_rwm"); ex(1, S_RD4, 7, "zw_rd4"); ex(1, S_WBV, 32'hDEAD_BEEF, "zw_wbv");
    tick();

    // Store with three wait cycles
    idle_in();
    MemWr_EX = 1; ALUout_EX = 32'h40; D = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      dm_bus.dm_ack = (i == 3);
      ex(0, S_STALL, (i < 3) ? 32'd1 : 32'd0, "st_stall");
      ex(0, S_REQ, 1, "st_req"); ex(0, S_WE, 1, "st_we");
      ex(0, S_ADDR, 32'h40, "st_addr"); ex(0, S_WDATA, 32'h1234_5678, "st_wdata");
      ex(1, S_RWM, 0, "st_rwm");
      tick();
    end

    // Load with one wait cycle: bubble, then completion with captured data
    idle_in();
    RegWr_EX = 1; MemRd_EX = 1; ALUout_EX = 32'h200; WBdata_EX = 2'b01; rd3 = 5'd3;
    dm_bus.dm_rdata = 32'h1111_1111;
    ex(0, S_STALL, 1, "ld1_stall0"); ex(1, S_RWM, 0, "ld1_bubble");
    tick();
    dm_bus.dm_ack = 1; dm_bus.dm_rdata = 32'hCAFE_F00D;
    ex(0, S_STALL, 0, "ld1_stall1");
    ex(1, S_RWM, 1, "ld1_rwm"); ex(1, S_RD4, 3, "ld1_rd4"); ex(1, S_WBV, 32'hCAFE_F00D, "ld1_wbv");
    tick();

    // Squashed load
    idle_in();
    RegWr_EX = 1; MemRd_EX = 1; RPzero_EX = 1; ALUout_EX = 32'h100;
    ex(0, S_REQ, 0, "sq_req"); ex(0, S_STALL, 0, "sq_stall"); ex(1, S_RWM, 0, "sq_rwm");
    tick();

    // ALU pass-through; misaligned value without a memory op is not an error
    idle_in();
    RegWr_EX = 1; ALUout_EX = 32'hA5A5_0003; rd3 = 5'd9;
    ex(0, S_REQ, 0, "alu_req");
    ex(1, S_RWM, 1, "alu_rwm"); ex(1, S_RD4, 9, "alu_rd4");
    ex(1, S_WBV, 32'hA5A5_0003, "alu_wbv"); ex(1, S_ERR, 0, "alu_err");
    tick();

    // NPC select
    idle_in();
    RegWr_EX = 1; WBdata_EX = 2'b10; npc3 = 32'h0000_1004; ALUout_EX = 32'h55; rd3 = 5'd31;
    ex(1, S_WBV, 32'h0000_1004, "npc_wbv"); ex(1, S_RD4, 31, "npc_rd4");
    tick();

    // Reserved select gives zero
    idle_in();
    RegWr_EX = 1; WBdata_EX = 2'b11; npc3 = 32'h77; ALUout_EX = 32'h99;
    ex(1, S_WBV, 0, "sel11_wbv");
    tick();

    // Load and store together behave as a store
    idle_in();
    MemRd_EX = 1; MemWr_EX = 1; ALUout_EX = 32'h80; dm_bus.dm_ack = 1;
    ex(0, S_REQ, 1, "rw_req"); ex(0, S_WE, 1, "rw_we"); ex(0, S_STALL, 0, "rw_stall");
    tick();

    // Ack in the fourth WAIT cycle beats the timeout
    idle_in();
    RegWr_EX = 1; MemRd_EX = 1; ALUout_EX = 32'h300; WBdata_EX = 2'b01; rd3 = 5'd5;
    for (int i = 0; i < 5; i++) begin
      dm_bus.dm_ack = (i == 4);
      dm_bus.dm_rdata = (i == 4) ? 32'h0BAD_F00D : 32'h0;
      ex(0, S_STALL, (i < 4) ? 32'd1 : 32'd0, "tack_stall");
      ex(0, S_REQ, 1, "tack_req");
      tick();
    end
    ex(0, S_RWM, 1, "tack_rwm"); ex(0, S_WBV, 32'h0BAD_F00D, "tack_wbv"); ex(0, S_ERR, 0, "tack_err");

    // No ack: four stall cycles, then abort with error
    for (int i = 0; i < 5; i++) begin
      dm_bus.dm_ack = 0;
      ex(0, S_STALL, (i < 4) ? 32'd1 : 32'd0, "tmo_stall");
      ex(0, S_REQ, (i < 4) ? 32'd1 : 32'd0, "tmo_req");
      tick();
    end
    ex(0, S_ERR, 1, "tmo_err"); ex(0, S_RWM, 0, "tmo_rwm");
    idle_in();
    ex(1, S_ERR, 1, "tmo_err_held");
    tick();

    rst = 1;
    tick();
    rst = 0;
    ex(0, S_ERR, 0, "clr_err");

    // Misaligned load
    RegWr_EX = 1; MemRd_EX = 1; ALUout_EX = 32'h102; rd3 = 5'd4;
    ex(0, S_REQ, 0, "mis_req"); ex(0, S_STALL, 0, "mis_stall");
    ex(1, S_ERR, 1, "mis_err"); ex(1, S_RWM, 0, "mis_rwm");
    tick();
    idle_in();
    ex(1, S_ERR, 1, "mis_err_held");
    tick();

    // Reset during the second WAIT cycle
    RegWr_EX = 1; MemRd_EX = 1; ALUout_EX = 32'h400; WBdata_EX = 2'b00; rd3 = 5'd31;
    ex(0, S_STALL, 1, "rw_w0");
    tick();
    ex(0, S_STALL, 1, "rw_w1");
    tick();
    rst = 1;
    ex(0, S_REQ, 0, "rmw_req"); ex(0, S_STALL, 0, "rmw_stall");
    tick();
    rst = 0;
    idle_in();
    ex(0, S_REQ, 0, "rmw_req_after"); ex(0, S_STALL, 0, "rmw_stall_after");
    ex(0, S_RWM, 0, "rmw_rwm"); ex(0, S_RD4, 0, "rmw_rd4");
    ex(0, S_WBV, 0, "rmw_wbv"); ex(0, S_ERR, 0, "rmw_err");
    tick();
    tick();
    tick();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
